iob_cache_tgen: RTL
===================

Name: iob_cache_tgen

Overview:
- Synthesizable IOb-native master traffic generator and self-checker for cache regression and on-FPGA soak tests.
- Sits in front of the cache frontend port.
- Writes a programmable, strided, pattern-generated burst of words, then reads the same words back with pipelined reads.
- Compares the returned data and reports the error count, first failing address, timeout and cycle count.

Parameters:
- ADDR_W, 24, byte address width of the IOb master port
- DATA_W, 32, data width; multiple of 8
- CNT_W, 16, width of word count, indexes and counters
- MAX_OUTST, 4, maximum reads in flight; power of two, ≥1
- TIMEOUT, 1024, cycles without handshake or response before abort

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1
- op_i  in  2  01=write only, 10=read/check only, 11=write then read/check, 00=no-op
- mode_i  in  1  0=affine data (seed_i+mult_i*idx), 1=address data (~addr, zero-extended/truncated to DATA_W)
- base_addr_i  in  ADDR_W  first byte address
- stride_i  in  ADDR_W  byte increment per word
- nwords_i  in  CNT_W  words per phase
- seed_i  in  DATA_W  affine offset
- mult_i  in  DATA_W  affine multiplier
- iob_valid_o  out  1  request valid
- iob_addr_o  out  ADDR_W  request byte address
- iob_wdata_o  out  DATA_W  write data
- iob_wstrb_o  out  DATA_W/8  all ones on writes, zero on reads
- iob_rvalid_i  in  1  read data valid
- iob_rdata_i  in  DATA_W  read data
- iob_ready_i  in  1  request accepted when iob_valid_o&iob_ready_i
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run end
- pass_o  out  1  1 when last run had err_cnt_o=0 and no timeout; held until next start
- timeout_o  out  1  last run aborted by timeout
- err_cnt_o  out  CNT_W  mismatches plus unexpected rvalids; saturates at all-ones
- first_err_addr_o  out  ADDR_W  address of first mismatch; 0 if none
- cycles_o  out  32  cycles from accepted start to done; saturating

Behaviour:
- Config latched on the accepted start; later input changes have no effect on the run.
- Reset values: all outputs 0, FSM in IDLE.
- Reset mid-run: iob_valid_o low the cycle after the reset edge; outstanding responses are discarded.
- FSM: IDLE -> (start, op≠00, nwords≠0) WRITE or READ.
- Start with op=00 or nwords=0: IDLE -> DONE; done_o on the next cycle, pass_o=1.
- WRITE: idx 0..nwords-1.
  - Address = base+idx*stride, modulo 2^ADDR_W.
  - valid, addr and wdata held stable until ready.
  - idx advances on the handshake; back-to-back handshakes allowed.
  - After the last handshake: op=11 -> READ, else DONE.
- READ: issues reads while outstanding<MAX_OUTST and issued<nwords.
  - outstanding += handshake, -= rvalid; both in the same cycle leave it unchanged.
  - After the last issue -> DRAIN.
- DRAIN: waits for outstanding=0, then -> DONE.
- Responses: in order; the response index counter regenerates the expected data independently of the issue counter.
  - Mismatch: err_cnt+1; first_err_addr recorded on the first mismatch only.
  - rvalid with outstanding=0, in any state: err_cnt+1, response ignored.
- Timeout: counter cleared on any handshake or rvalid, or on leaving IDLE.
  - Reaching TIMEOUT in WRITE/READ/DRAIN: drop valid, set timeout_o, -> DONE.
- DONE: one cycle, done_o=1, busy_o=0 next cycle; -> IDLE.
- busy_o is 1 from the cycle after start through DONE.
- Status outputs cleared on the next accepted start.
- Arithmetic: mult_i*idx truncated to DATA_W; address and data wrap silently.

Test Plan:
- base=0, stride=4, nwords=5, mode=0, seed=0, mult=3, op=11, cache model:
  - writes to 0,4,8,12,16 with data 0,3,6,9,12, wstrb=F;
  - reads match; done_o pulses once, pass_o=1, err_cnt_o=0.
- Same run, bench corrupts response index 2 to 0xDEAD → err_cnt_o=1, first_err_addr_o=8, pass_o=0.
- nwords=32, MAX_OUTST=4, ready always 1, rvalid 3 cycles after accept → outstanding never exceeds 4, 32 responses, pass_o=1.
- base=0xFFFFF8, stride=4, nwords=4 → addresses 0xFFFFF8, 0xFFFFFC, 0x000000, 0x000004.
- iob_ready_i held 0, TIMEOUT=1024 → timeout_o=1, done_o pulses about 1025 cycles after start, iob_valid_o=0 after abort.
- rst_i asserted during READ with 2 reads outstanding, then a new start with nwords=0 → outputs 0 after the reset edge, late rvalids counted as errors until start; after start: done next cycle, pass_o=1, err_cnt_o=0.

Source files
------------

// File: rtl/iob_cache_tgen.sv
// iob_cache_tgen
//   IOb-native master traffic generator and self-checker. Writes a strided,
//   pattern-generated burst of words, reads the same words back with
//   pipelined reads (up to MAX_OUTST in flight) and compares the returned
//   data against an independently regenerated expected stream.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 one-cycle start pulse, accepted only in IDLE
//   op_i                    01 write, 10 read/check, 11 write then read/check
//   mode_i                  0 affine data seed+mult*idx, 1 data = ~addr
//   base_addr_i, stride_i   first byte address and byte increment per word
//   nwords_i                words per phase
//   seed_i, mult_i          affine pattern coefficients
//   iob_*                   IOb master request/response channel
//   busy_o, done_o          run in progress / one-cycle end-of-run pulse
//   pass_o, timeout_o       result of the last run
//   err_cnt_o               mismatches plus unexpected rvalids (saturating)
//   first_err_addr_o        address of the first mismatch
//   cycles_o                active cycles of the last run (saturating)
module iob_cache_tgen #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic                mode_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W-1:0]   stride_i,
  input  logic [CNT_W-1:0]    nwords_i,
  input  logic [DATA_W-1:0]   seed_i,
  input  logic [DATA_W-1:0]   mult_i,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic [31:0]         cycles_o
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;

  // Run configuration captured on the accepted start
  logic                cfg_rd;
  logic                cfg_mode;
  logic [ADDR_W-1:0]   cfg_base;
  logic [ADDR_W-1:0]   cfg_stride;
  logic [CNT_W-1:0]    cfg_nwords;
  logic [DATA_W-1:0]   cfg_seed;
  logic [DATA_W-1:0]   cfg_mult;

  // Issue side: index and running affine value (address lives in iob_addr_o)
  logic [CNT_W-1:0]    iss_idx;
  logic [DATA_W-1:0]   iss_aff;

  // Response side: regenerates the expected stream on its own
  logic [ADDR_W-1:0]   rsp_addr;
  logic [DATA_W-1:0]   rsp_aff;

  logic [OUT_W-1:0]    outst;
  logic [OUT_W-1:0]    outst_nxt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                err_seen;

  logic                active;
  logic                req_hs;
  logic                rd_hs;
  logic                rsp_ok;
  logic                rsp_stray;
  logic                rsp_bad;
  logic                last_iss;
  logic                tmo_hit;
  logic [DATA_W-1:0]   exp_data;
  logic [CNT_W-1:0]    err_nxt;
  logic [ADDR_W-1:0]   iss_addr_nxt;
  logic [DATA_W-1:0]   iss_aff_nxt;

  // Pattern word: affine value, or the inverted address zero-extended or
  // truncated to DATA_W. The inversion is done at ADDR_W before resizing so
  // the extension bits stay zero.
  function automatic logic [DATA_W-1:0] gen_data(input logic m,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] aff);
    logic [ADDR_W-1:0] na;
    logic [EXT_W-1:0]  ext;
    na  = ~a;
    ext = EXT_W'(na);
    gen_data = m ? ext[DATA_W-1:0] : aff;
  endfunction

  assign active       = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign req_hs       = iob_valid_o & iob_ready_i;
  assign rd_hs        = req_hs && (state == S_READ);
  assign rsp_ok       = iob_rvalid_i && (outst != '0);
  assign rsp_stray    = iob_rvalid_i && (outst == '0);
  assign exp_data     = gen_data(cfg_mode, rsp_addr, rsp_aff);
  assign rsp_bad      = rsp_ok && (iob_rdata_i != exp_data);
  assign last_iss     = (iss_idx == cfg_nwords - 1'b1);
  assign iss_addr_nxt = iob_addr_o + cfg_stride;
  assign iss_aff_nxt  = iss_aff + cfg_mult;
  assign tmo_hit      = active && !req_hs && !iob_rvalid_i &&
                        (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign err_nxt      = ((rsp_bad || rsp_stray) && (err_cnt_o != '1)) ?
                        err_cnt_o + 1'b1 : err_cnt_o;

  // A read accept and a response in the same cycle cancel out
  always_comb begin
    outst_nxt = outst;
    if (rd_hs && !rsp_ok)
      outst_nxt = outst + 1'b1;
    else if (!rd_hs && rsp_ok)
      outst_nxt = outst - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= S_IDLE;
      cfg_rd           <= 1'b0;
      cfg_mode         <= 1'b0;
      cfg_base         <= '0;
      cfg_stride       <= '0;
      cfg_nwords       <= '0;
      cfg_seed         <= '0;
      cfg_mult         <= '0;
      iss_idx          <= '0;
      iss_aff          <= '0;
      rsp_addr         <= '0;
      rsp_aff          <= '0;
      outst            <= '0;
      tmo_cnt          <= '0;
      err_seen         <= 1'b0;
      iob_valid_o      <= 1'b0;
      iob_addr_o       <= '0;
      iob_wdata_o      <= '0;
      iob_wstrb_o      <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      cycles_o         <= '0;
    end else begin
      done_o    <= 1'b0;
      outst     <= outst_nxt;
      err_cnt_o <= err_nxt;

      if (rsp_bad && !err_seen) begin
        err_seen         <= 1'b1;
        first_err_addr_o <= rsp_addr;
      end

      if (rsp_ok) begin
        rsp_addr <= rsp_addr + cfg_stride;
        rsp_aff  <= rsp_aff + cfg_mult;
      end

      if (req_hs || iob_rvalid_i)
        tmo_cnt <= '0;
      else if (active)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (active && (cycles_o != '1))
        cycles_o <= cycles_o + 32'd1;

      if (tmo_hit) begin
        // Abort: in-flight responses are forgotten, so any that still
        // arrive later count as unexpected
        state       <= S_DONE;
        done_o      <= 1'b1;
        timeout_o   <= 1'b1;
        pass_o      <= 1'b0;
        outst       <= '0;
        iob_valid_o <= 1'b0;
        iob_wstrb_o <= '0;
        iob_wdata_o <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              cfg_rd           <= op_i[1];
              cfg_mode         <= mode_i;
              cfg_base         <= base_addr_i;
              cfg_stride       <= stride_i;
              cfg_nwords       <= nwords_i;
              cfg_seed         <= seed_i;
              cfg_mult         <= mult_i;
              iss_idx          <= '0;
              iss_aff          <= seed_i;
              rsp_addr         <= base_addr_i;
              rsp_aff          <= seed_i;
              tmo_cnt          <= '0;
              err_seen         <= 1'b0;
              err_cnt_o        <= '0;
              first_err_addr_o <= '0;
              timeout_o        <= 1'b0;
              pass_o           <= 1'b0;
              cycles_o         <= '0;
              busy_o           <= 1'b1;
              iob_addr_o       <= base_addr_i;
              if ((op_i == 2'b00) || (nwords_i == '0)) begin
                state  <= S_DONE;
                done_o <= 1'b1;
                pass_o <= 1'b1;
              end else if (op_i[0]) begin
                state       <= S_WRITE;
                iob_valid_o <= 1'b1;
                iob_wstrb_o <= '1;
                iob_wdata_o <= gen_data(mode_i, base_addr_i, seed_i);
              end else begin
                state       <= S_READ;
                iob_valid_o <= 1'b1;
                iob_wstrb_o <= '0;
                iob_wdata_o <= '0;
              end
            end
          end

          S_WRITE: begin
            if (req_hs) begin
              if (last_iss) begin
                if (cfg_rd) begin
                  // Restart the issue side at the base for the read-back
                  state       <= S_READ;
                  iss_idx     <= '0;
                  iss_aff     <= cfg_seed;
                  iob_addr_o  <= cfg_base;
                  iob_valid_o <= 1'b1;
                  iob_wstrb_o <= '0;
                  iob_wdata_o <= '0;
                end else begin
                  state       <= S_DONE;
                  done_o      <= 1'b1;
                  pass_o      <= (err_nxt == '0);
                  iob_valid_o <= 1'b0;
                  iob_wstrb_o <= '0;
                  iob_wdata_o <= '0;
                end
              end else begin
                iss_idx     <= iss_idx + 1'b1;
                iss_aff     <= iss_aff_nxt;
                iob_addr_o  <= iss_addr_nxt;
                iob_wdata_o <= gen_data(cfg_mode, iss_addr_nxt, iss_aff_nxt);
              end
            end
          end

          S_READ: begin
            if (rd_hs && last_iss) begin
              state       <= S_DRAIN;
              iob_valid_o <= 1'b0;
            end else begin
              if (rd_hs) begin
                iss_idx    <= iss_idx + 1'b1;
                iob_addr_o <= iss_addr_nxt;
              end
              // Once raised, valid can only stay high: outst cannot grow
              // without a handshake
              iob_valid_o <= (outst_nxt < OUT_W'(MAX_OUTST));
            end
          end

          S_DRAIN: begin
            if (outst_nxt == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
              pass_o <= (err_nxt == '0);
            end
          end

          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
